// File: rtl/snn_pkg.sv
// Shared defaults, state encoding and weight-ROM layout for the SNN inference sequencer.
package snn_pkg;

  localparam int IN_NUM_DEF  = 784;
  localparam int HID_NUM_DEF = 32;
  localparam int OUT_NUM_DEF = 10;
  localparam int ACC_W_DEF   = 24;
  localparam int SHIFT_DEF   = 4;

  // Output-layer weights start right after the hidden-layer block in the ROM.
  localparam int L2_BASE = HID_NUM_DEF * IN_NUM_DEF;

  typedef enum logic [2:0] {
    IDLE,
    L1_ISSUE,
    L1_DRAIN,
    L1_WR,
    L2_ISSUE,
    L2_DRAIN,
    L2_WR,
    FIN
  } state_t;

endpackage

// File: rtl/snn_mac.sv
// Signed multiply-accumulate shared by both layers: unsigned 8-bit activation times signed 8-bit weight.
module snn_mac
  import snn_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [7:0]              a,
  input  logic [7:0]              b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] prod;

  assign a_ext = {{(ACC_W-8){1'b0}}, a};
  assign b_ext = {{(ACC_W-8){b[7]}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + prod;
  end

endmodule

// File: rtl/snn_infer_ctrl.sv
// Inference sequencer for a 784->32->10 fully-connected SNN: walks the input buffer, streams
// weights from an external ROM, stores ReLU/saturated hidden activations and reports the argmax.
//
// state    | meaning
// IDLE     | waiting for start; counters and w_addr parked at 0
// L1_ISSUE | present in_addr/w_addr for one hidden-neuron input term
// L1_DRAIN | accumulate the last hidden term still in flight
// L1_WR    | ReLU, shift, saturate into hid[n]; clear accumulator
// L2_ISSUE | present hidden index and output weight address
// L2_DRAIN | accumulate the last output term still in flight
// L2_WR    | argmax update; clear accumulator
// FIN      | done pulse with digit valid
module snn_infer_ctrl
  import snn_pkg::*;
#(
  parameter int IN_NUM  = IN_NUM_DEF,
  parameter int HID_NUM = HID_NUM_DEF,
  parameter int OUT_NUM = OUT_NUM_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SHIFT   = SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  in_addr,
  input  logic        in_q,
  output logic [14:0] w_addr,
  input  logic [7:0]  w_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit
);

  localparam int NW = (HID_NUM > 1) ? $clog2(HID_NUM) : 1;
  localparam logic [9:0]              I_LAST = 10'(IN_NUM - 1);
  localparam logic [NW-1:0]           H_LAST = NW'(HID_NUM - 1);
  localparam logic [3:0]              K_LAST = 4'(OUT_NUM - 1);
  localparam logic signed [ACC_W-1:0] SAT    = ACC_W'(255);

  state_t state, state_nxt;

  logic [9:0]              i_cnt;
  logic [NW-1:0]           n_cnt;
  logic [NW-1:0]           j_cnt;
  logic [3:0]              k_cnt;
  logic [14:0]             w_cnt;
  logic [7:0]              hid [HID_NUM];
  logic [7:0]              hid_q;
  logic                    pend;
  logic                    l2_q;
  logic                    mac_clr;
  logic [7:0]              mac_a;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [ACC_W-1:0] best;
  logic [3:0]              idx;
  logic                    better;
  logic [7:0]              hid_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = L1_ISSUE;
      L1_ISSUE: if (i_cnt == I_LAST) state_nxt = L1_DRAIN;
      L1_DRAIN: state_nxt = L1_WR;
      L1_WR:    state_nxt = (n_cnt == H_LAST) ? L2_ISSUE : L1_ISSUE;
      L2_ISSUE: if (j_cnt == H_LAST) state_nxt = L2_DRAIN;
      L2_DRAIN: state_nxt = L2_WR;
      L2_WR:    state_nxt = (k_cnt == K_LAST) ? FIN : L2_ISSUE;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE) && (state != FIN);
  assign done    = (state == FIN);
  assign in_addr = i_cnt;
  assign w_addr  = w_cnt;
  assign mac_clr = (state == IDLE) || (state == L1_WR) || (state == L2_WR);
  // Layer 1 multiplies by the input bit, so the weight passes through or is zeroed.
  assign mac_a   = l2_q ? hid_q : {7'b0, in_q};

  snn_mac #(.ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (pend),
    .a   (mac_a),
    .b   (w_data),
    .acc (acc)
  );

  assign acc_sh = acc >>> SHIFT;
  // Strict compare keeps the lowest index on ties; the first output always seeds best.
  assign better = (k_cnt == 4'd0) || (acc > best);

  always_comb begin
    hid_val = 8'd0;
    if (!acc[ACC_W-1])
      hid_val = (acc_sh > SAT) ? 8'hFF : acc_sh[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= '0;
      n_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
      w_cnt <= '0;
      hid_q <= '0;
      pend  <= 1'b0;
      l2_q  <= 1'b0;
      best  <= '0;
      idx   <= '0;
      digit <= '0;
      for (int h = 0; h < HID_NUM; h++)
        hid[h] <= '0;
    end else begin
      // Operands return one cycle after issue, matching the registered buffer and ROM.
      pend  <= (state == L1_ISSUE) || (state == L2_ISSUE);
      l2_q  <= (state == L2_ISSUE);
      hid_q <= hid[j_cnt];
      case (state)
        IDLE: begin
          i_cnt <= '0;
          n_cnt <= '0;
          j_cnt <= '0;
          k_cnt <= '0;
          w_cnt <= '0;
        end
        L1_ISSUE: begin
          w_cnt <= w_cnt + 15'd1;
          i_cnt <= (i_cnt == I_LAST) ? 10'd0 : i_cnt + 10'd1;
        end
        L1_WR: begin
          hid[n_cnt] <= hid_val;
          n_cnt      <= (n_cnt == H_LAST) ? '0 : n_cnt + 1'b1;
        end
        L2_ISSUE: begin
          w_cnt <= w_cnt + 15'd1;
          j_cnt <= (j_cnt == H_LAST) ? '0 : j_cnt + 1'b1;
        end
        L2_WR: begin
          if (better) begin
            best <= acc;
            idx  <= k_cnt;
          end
          if (k_cnt == K_LAST) begin
            digit <= better ? k_cnt : idx;
            k_cnt <= '0;
          end else begin
            k_cnt <= k_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Scoreboard bench for snn_infer_ctrl with 1-cycle-latency input buffer and weight ROM models.
module tb_snn_infer_ctrl;
  import snn_pkg::*;

  localparam int LAT = HID_NUM_DEF * (IN_NUM_DEF + 2) + OUT_NUM_DEF * (HID_NUM_DEF + 2) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  in_addr;
  logic        in_q = 1'b0;
  logic [14:0] w_addr;
  logic [7:0]  w_data = 8'd0;
  logic        busy;
  logic        done;
  logic [3:0]  digit;

  snn_infer_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_addr (in_addr),
    .in_q    (in_q),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .busy    (busy),
    .done    (done),
    .digit   (digit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] digit;
    int         st;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               done_cnt = 0;
  logic             img [IN_NUM_DEF];
  logic signed [7:0] hw = 8'sd0;
  logic signed [7:0] ow [OUT_NUM_DEF];
  bit               trace_en = 1'b0;
  int               w_inc = 0;
  int               n783 = 0;
  int               trace_err = 0;
  logic [14:0]      prev_w = '0;
  logic [9:0]       prev_in = '0;

  function automatic logic [7:0] rom(input logic [14:0] a);
    int ai;
    ai = int'(a);
    if (ai < L2_BASE) return hw;
    if (ai < L2_BASE + OUT_NUM_DEF * HID_NUM_DEF) return ow[(ai - L2_BASE) / HID_NUM_DEF];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= rom(w_addr);
    in_q   <= img[in_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("digit", int'(digit), int'(e.digit));
        chk("latency", cyc - e.st, LAT);
        chk("busy_at_done", int'(busy), 0);
        if (trace_en) begin
          chk("w_addr_steps", w_inc, L2_BASE + OUT_NUM_DEF * HID_NUM_DEF);
          chk("in_addr_783_hits", n783, HID_NUM_DEF);
          chk("trace_errors", trace_err, 0);
        end
      end
    end
  end

  always @(negedge clk) begin : tracer
    if (trace_en && busy) begin
      if (w_addr != prev_w) begin
        if (w_addr == prev_w + 15'd1) w_inc++;
        else trace_err++;
      end
      if (in_addr == 10'd783) n783++;
      if (!(in_addr == prev_in + 10'd1 || in_addr == 10'd0)) trace_err++;
      prev_w  = w_addr;
      prev_in = in_addr;
    end
  end

  task automatic set_cfg(input logic signed [7:0] h);
    hw = h;
    for (int k = 0; k < OUT_NUM_DEF; k++) ow[k] = 8'sd0;
    for (int i = 0; i < IN_NUM_DEF; i++) img[i] = 1'b1;
  endtask

  task automatic launch(input logic [3:0] exp_digit, input bit expect_done);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (expect_done) begin
      e.digit = exp_digit;
      e.st    = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int dc;
    int t;
    dc = done_cnt;
    t  = 0;
    while (done_cnt == dc && t < 30000) begin
      @(posedge clk);
      t++;
    end
    chk(name, int'(done_cnt != dc), 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_in_addr", int'(in_addr), 0);
    chk("rst_w_addr", int'(w_addr), 0);
  endtask

  initial begin
    set_cfg(8'sd0);
    #1 rst = 1'b1;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Hidden weights -1: ReLU zeroes every activation, all outputs tie at 0.
    set_cfg(-8'sd1);
    ow[0] = -8'sd1;
    ow[5] = 8'sd1;
    launch(4'd0, 1'b1);
    wait_done("done_seen_relu");

    // hid=49, out7=1568; address trace checked, stray start pulses ignored.
    set_cfg(8'sd1);
    ow[7]     = 8'sd1;
    prev_w    = '0;
    prev_in   = '0;
    w_inc     = 0;
    n783      = 0;
    trace_err = 0;
    trace_en  = 1'b1;
    launch(4'd7, 1'b1);
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_seen_plus1");
    trace_en = 1'b0;
    repeat (20) @(negedge clk);
    chk("digit_held", int'(digit), 7);

    // Abort at cycle 1000 of a run: outputs clear at once, no done follows.
    set_cfg(8'sd127);
    ow[3] = 8'sd1;
    launch(4'd0, 1'b0);
    repeat (998) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // Hidden weights +127 saturate to 255; out3=8160.
    launch(4'd3, 1'b1);
    wait_done("done_seen_sat");
    repeat (10) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", done_cnt, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
